// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame constants, value limits and parser state encoding
package uart_cmd_pkg;
  localparam logic [7:0] HDR = 8'hA5;
  localparam logic [7:0] CMD_TIME = 8'h01;
  localparam logic [7:0] CMD_ALARM = 8'h02;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX = 8'd59;
  localparam logic [7:0] SEC_MAX = 8'd59;
  typedef enum logic [1:0] {IDLE, CMD, PAYLOAD, CHECK} state_t;
endpackage

// File: rtl/uart_cmd_parser_byte_timeout.sv
// byte_timeout: down-counter reloaded on clear, flags expiry TICKS cycles after the last clear while run is high
module byte_timeout #(
  parameter int TICKS = 120000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TICKS);
  logic [W-1:0] cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else if (clear) cnt <= W'(TICKS - 1);
    else if (run && cnt != '0) cnt <= cnt - W'(1);
  assign expired = run & ~clear & (cnt == '0);
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes framed set-time/set-alarm commands and queues a one-byte ACK/NAK reply
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       ack_en,
  output logic [7:0] ack_data,
  output logic       set_time,
  output logic       set_alarm,
  output logic [7:0] hour_out,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       frame_err
);
  localparam int TICKS = CLK_FREQ / 1000 * TIMEOUT_MS;
  state_t state;
  logic [1:0] idx, last;
  logic [2:0][7:0] pl;
  logic [7:0] chk;
  logic alarm, pending, expired, ok;
  byte_timeout #(.TICKS(TICKS)) u_timeout (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .clear(rx_valid),
    .run(state != IDLE),
    .expired(expired)
  );
  // The reply leaves on the first cycle the transmitter is free
  assign ack_en = pending & ~tx_busy;
  assign ok = rx_data == chk && pl[0] <= HOUR_MAX && pl[1] <= MIN_MAX && (alarm || pl[2] <= SEC_MAX);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      pl <= '0;
      chk <= '0;
      alarm <= 1'b0;
      pending <= 1'b0;
      ack_data <= '0;
      set_time <= 1'b0;
      set_alarm <= 1'b0;
      hour_out <= '0;
      min_out <= '0;
      sec_out <= '0;
      frame_err <= 1'b0;
    end else begin
      set_time <= 1'b0;
      set_alarm <= 1'b0;
      frame_err <= 1'b0;
      if (ack_en) pending <= 1'b0;
      if (rx_valid)
        case (state)
          IDLE: if (rx_data == HDR) state <= CMD;
          CMD: begin
            chk <= rx_data;
            idx <= '0;
            alarm <= rx_data == CMD_ALARM;
            last <= rx_data == CMD_TIME ? 2'd2 : 2'd1;
            if (rx_data == CMD_TIME || rx_data == CMD_ALARM) state <= PAYLOAD;
            else begin
              state <= IDLE;
              frame_err <= 1'b1;
              pending <= 1'b1;
              ack_data <= NAK;
            end
          end
          PAYLOAD: begin
            pl[idx] <= rx_data;
            chk <= chk ^ rx_data;
            idx <= idx + 2'd1;
            if (idx == last) state <= CHECK;
          end
          CHECK: begin
            state <= IDLE;
            pending <= 1'b1;
            ack_data <= ok ? ACK : NAK;
            frame_err <= ~ok;
            if (ok) begin
              hour_out <= pl[0];
              min_out <= pl[1];
              if (!alarm) sec_out <= pl[2];
              set_time <= ~alarm;
              set_alarm <= alarm;
            end
          end
        endcase
      else if (expired) begin
        state <= IDLE;
        frame_err <= 1'b1;
      end
    end
endmodule
